lc3_mem_ctrl: RTL
=================

# lc3_mem_ctrl

Memory and memory-mapped I/O controller on the LC-3 datapath's memory port. Takes MAR, MDR write data, MIO_EN and R_W from the datapath. Decodes main memory versus the device registers (KBSR/KBDR/DSR/DDR/MCR). Returns read data and the one-cycle ready pulse R that releases the control FSM from its memory-wait states. Also produces the keyboard interrupt request and vector consumed by the control unit.

## Interface
- MEM_LATENCY, 4: cycles from access acceptance to R for main memory; legal range ≥1.
- ADDR_WIDTH, 16: main-memory array address width; the array holds 2^ADDR_WIDTH words.
- KB_VECTOR, 8'h80: interrupt vector reported for the keyboard.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- mio_en  in  1  access request, sampled in IDLE.
- r_w  in  1  1 = write, 0 = read; sampled with mio_en.
- mar  in  16  access address; sampled with mio_en.
- mdr_in  in  16  write data; sampled with mio_en.
- mdr_out  out  16  read data; registered.
- r  out  1  ready; high for exactly one cycle per access.
- kb_valid  in  1  keyboard character offered.
- kb_data  in  8  keyboard character.
- kb_ready  out  1  = ~KBSR[15].
- disp_valid  out  1  display character offered.
- disp_data  out  8  display character.
- disp_ready  in  1  display sink accepts.
- int_req  out  1  = KBSR[15] & KBSR[14].
- int_vec  out  8  constant KB_VECTOR.
- run  out  1  = MCR[15].

## Operation
- FSM states are IDLE, BUSY and DONE.
  - IDLE → BUSY when mio_en=1; latch mar, r_w and mdr_in, and load the counter.
  - BUSY decrements the counter and moves to DONE when the count reaches 0.
  - DONE asserts r, commits the access, then → IDLE unconditionally.
- Counter load value:
  - MEM_LATENCY−1 for main memory.
  - 0 for device-region addresses (≥16'hFE00), so device accesses take 2 cycles to DONE.
- Address decode:
  - 16'hFE00 is KBSR: bit15 ready (read-only), bit14 IE (read/write), other bits read 0.
  - 16'hFE02 is KBDR: {8'h00, char}, read-only.
  - 16'hFE04 is DSR: bit15 ready, read-only.
  - 16'hFE06 is DDR: write-only, reads 0.
  - 16'hFFFE is MCR: read/write full 16 bits.
  - Any other address ≥16'hFE00 reads 16'h0000 and ignores writes.
  - Addresses below 16'hFE00 use the main array, indexed by mar[ADDR_WIDTH-1:0].
- Commit at the DONE edge:
  - Memory writes happen on that edge.
  - mdr_out is loaded on the edge entering DONE, so it is valid while r=1 and held until the next read reaches DONE.
  - Writes leave mdr_out unchanged.
- Keyboard:
  - On the edge where kb_valid & kb_ready: KBDR ← kb_data and KBSR[15] ← 1.
  - A read of KBDR clears KBSR[15] at its DONE edge.
  - A capture and a clear cannot coincide because kb_ready=0 while KBSR[15]=1.
- Display:
  - A write to DDR while DSR[15]=1 loads disp_data, sets disp_valid and clears DSR[15].
  - A write to DDR while DSR[15]=0 is dropped.
  - disp_valid & disp_ready clears disp_valid and sets DSR[15] on the same edge.
- Values after reset:
  - state IDLE, r=0, mdr_out=0.
  - KBSR=0, KBDR=0, DSR[15]=1, disp_valid=0, disp_data=0.
  - MCR=16'h8000, so int_req=0 and run=1.
  - Memory array contents are not reset.

## Timing
- Latency from the mio_en-sampled edge to r high:
  - Main memory: MEM_LATENCY+1 cycles.
  - Device registers: 2 cycles.
- mio_en may stay high through DONE. The value sampled in the following IDLE cycle starts the next access, which gives back-to-back accesses with one idle cycle.
- Changes to mar, r_w or mdr_in during BUSY or DONE are ignored.
- Reset mid-access: return to IDLE with r=0 and no memory/register write committed; device registers take their reset values.
- A write to KBSR in the same cycle as a keyboard capture: IE takes the written value and bit15 is set by the capture.

## Structure
- Package lc3_mem_pkg holds the device addresses (KBSR_ADDR, KBDR_ADDR, DSR_ADDR, DDR_ADDR, MCR_ADDR), DEV_BASE=16'hFE00, and the state enum.
- Sub-module lc3_mem_array is a single-port synchronous RAM with parameter ADDR_WIDTH and ports clk, we, addr, wdata, rdata.
- FSM, counter, decode and device registers live in lc3_mem_ctrl.

## Test plan
- Write 16'hBEEF to 16'h3000, then read 16'h3000 → r pulses at MEM_LATENCY+1 cycles after each request; mdr_out=16'hBEEF during the read's r cycle.
- kb_valid with kb_data=8'h41 → KBSR reads 16'h8000 and kb_ready=0. Read KBDR → 16'h0041, then KBSR reads 16'h0000.
- Write KBSR=16'h4000, then offer a key → int_req=1 and int_vec=8'h80. Read KBDR → int_req=0.
- Write DDR=16'h0058 with disp_ready=0 → disp_valid=1, disp_data=8'h58, DSR=0. A second DDR write is dropped. disp_ready=1 → DSR=16'h8000.
- Assert reset during BUSY of a write of 16'h1234 to 16'h4000 → r never pulses; a later read of 16'h4000 does not return 16'h1234 (array preloaded with 16'h0000).
- Write MCR=16'h0000 → run=0. Read 16'hFE08 → 16'h0000 with r at 2 cycles.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc3_mem_pkg
// Description : Shared definitions for the LC-3 memory controller. Holds the
//               device-register address map, reset constants and the access
//               FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3_mem_pkg;

    // Device region: any address at or above DEV_BASE bypasses the array
    localparam logic [15:0] DEV_BASE  = 16'hFE00;
    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
    localparam logic [15:0] MCR_ADDR  = 16'hFFFE;

    // Machine starts out running
    localparam logic [15:0] MCR_RESET = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_dev(input logic [15:0] addr);
        return addr >= DEV_BASE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : lc3_mem_array
// Description : Single-port synchronous RAM, 16-bit words, 2^ADDR_WIDTH deep.
//               Read data is registered (one cycle after addr); writes occur
//               on the rising edge with we high. Contents are not reset.
// Ports       : clk   - clock
//               we    - write enable
//               addr  - word address
//               wdata - write data
//               rdata - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_mem_array #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [15:0]           wdata,
    output logic [15:0]           rdata
);

    logic [15:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata <= mem_q[addr];
    end

endmodule
`default_nettype wire

// File: rtl/lc3_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lc3_mem_ctrl
// Description : LC-3 memory / memory-mapped I/O controller. Accepts an access
//               from the datapath in IDLE, waits in BUSY, then pulses r for
//               one cycle in DONE where the access is committed. Hosts the
//               keyboard, display and machine-control registers.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               mio_en, r_w, mar,     - access request, direction, address,
//               mdr_in                  write data
//               mdr_out, r            - registered read data, ready pulse
//               kb_valid, kb_data,    - keyboard character input handshake
//               kb_ready
//               disp_valid, disp_data,- display character output handshake
//               disp_ready
//               int_req, int_vec      - keyboard interrupt request / vector
//               run                   - MCR[15]
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int          MEM_LATENCY = 4,
    parameter int          ADDR_WIDTH  = 16,
    parameter logic [7:0]  KB_VECTOR   = 8'h80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mio_en,
    input  logic        r_w,
    input  logic [15:0] mar,
    input  logic [15:0] mdr_in,
    output logic [15:0] mdr_out,
    output logic        r,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic        int_req,
    output logic [7:0]  int_vec,
    output logic        run
);

    localparam int               CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] MEM_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        addr_q, addr_d;
    logic               rw_q, rw_d;
    logic [15:0]        wdata_q, wdata_d;

    logic [15:0]        mdr_out_q;
    logic               kbsr_rdy_q, kbsr_ie_q;
    logic [7:0]         kbdr_q;
    logic               dsr_rdy_q;
    logic               disp_valid_q;
    logic [7:0]         disp_data_q;
    logic [15:0]        mcr_q;

    logic [15:0]        ram_rdata;
    logic [15:0]        rd_data;
    logic               acc_dev;
    logic               rd_commit;
    logic               wr_commit;
    logic               load_rd;

    // ------------------------------------------------------------------
    // Access FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (mio_en) begin
                    state_d = BUSY;
                    addr_d  = mar;
                    rw_d    = r_w;
                    wdata_d = mdr_in;
                    cnt_d   = is_dev(mar) ? '0 : MEM_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
        end
    end

    assign acc_dev   = is_dev(addr_q);
    assign rd_commit = (state_q == DONE) && !rw_q;
    assign wr_commit = (state_q == DONE) && rw_q;
    // mdr_out loads on the edge that enters DONE
    assign load_rd   = (state_q == BUSY) && (cnt_q == '0) && !rw_q;

    // ------------------------------------------------------------------
    // Main memory. In IDLE the RAM is addressed straight from mar so that
    // its registered output is already valid one edge after acceptance;
    // this keeps MEM_LATENCY=1 correct.
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;

    assign ram_addr = (state_q == IDLE) ? mar[ADDR_WIDTH-1:0] : addr_q[ADDR_WIDTH-1:0];
    assign ram_we   = wr_commit && !acc_dev && !reset;

    lc3_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Read data select
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = 16'h0000;
        if (!acc_dev) begin
            rd_data = ram_rdata;
        end else begin
            case (addr_q)
                KBSR_ADDR: rd_data = {kbsr_rdy_q, kbsr_ie_q, 14'h0000};
                KBDR_ADDR: rd_data = {8'h00, kbdr_q};
                DSR_ADDR:  rd_data = {dsr_rdy_q, 15'h0000};
                MCR_ADDR:  rd_data = mcr_q;
                default:   rd_data = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mdr_out_q <= 16'h0000;
        end else if (load_rd) begin
            mdr_out_q <= rd_data;
        end
    end

    // ------------------------------------------------------------------
    // Device registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            kbsr_rdy_q   <= 1'b0;
            kbsr_ie_q    <= 1'b0;
            kbdr_q       <= 8'h00;
            dsr_rdy_q    <= 1'b1;
            disp_valid_q <= 1'b0;
            disp_data_q  <= 8'h00;
            mcr_q        <= MCR_RESET;
        end else begin
            // Capture only when empty, so it never collides with the
            // read-clear below
            if (kb_valid && !kbsr_rdy_q) begin
                kbdr_q     <= kb_data;
                kbsr_rdy_q <= 1'b1;
            end else if (rd_commit && addr_q == KBDR_ADDR) begin
                kbsr_rdy_q <= 1'b0;
            end

            if (wr_commit && addr_q == KBSR_ADDR) begin
                kbsr_ie_q <= wdata_q[14];
            end

            // DSR ready implies disp_valid low, so the two branches are
            // mutually exclusive in practice
            if (wr_commit && addr_q == DDR_ADDR && dsr_rdy_q) begin
                disp_data_q  <= wdata_q[7:0];
                disp_valid_q <= 1'b1;
                dsr_rdy_q    <= 1'b0;
            end else if (disp_valid_q && disp_ready) begin
                disp_valid_q <= 1'b0;
                dsr_rdy_q    <= 1'b1;
            end

            if (wr_commit && addr_q == MCR_ADDR) begin
                mcr_q <= wdata_q;
            end
        end
    end

    assign mdr_out    = mdr_out_q;
    assign r          = (state_q == DONE);
    assign kb_ready   = !kbsr_rdy_q;
    assign int_req    = kbsr_rdy_q && kbsr_ie_q;
    assign int_vec    = KB_VECTOR;
    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;
    assign run        = mcr_q[15];

endmodule
`default_nettype wire
